// File: rtl/memoria_buffer_escrita.sv
// memoria_buffer_escrita
// Main-memory stage behind the 2-way write-back cache. Write-backs land in
// a small FIFO write buffer that drains one entry per idle edge into a
// word-addressed backing array. Reads capture their value at acceptance,
// forwarding the youngest pending buffer entry for the same address.
// The value is returned READ_LAT edges later.
//
// Optional feature: define WBUF_COALESCE_EN to merge a write into a pending
// buffer entry with the same address. Such a write is also accepted while
// the buffer is full.
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-high
//   wren       write request
//   rden       read request (ignored when wren is also high)
//   endereco   request address
//   dado_in    write data
//   q          registered read data, held until the next read returns
//   q_valid    one-cycle pulse when q carries a returned read
//   busy       request not accepted this cycle
//   buf_count  occupied write-buffer entries
module memoria_buffer_escrita #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 3,
    parameter int BUF_DEPTH = 2,
    parameter int READ_LAT  = 2
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               wren,
    input  logic                               rden,
    input  logic [ADDR_W-1:0]                  endereco,
    input  logic [DATA_W-1:0]                  dado_in,
    output logic [DATA_W-1:0]                  q,
    output logic                               q_valid,
    output logic                               busy,
    output logic [$clog2(BUF_DEPTH+1)-1:0]     buf_count
);

    localparam int CNT_W       = $clog2(BUF_DEPTH + 1);
    localparam int PTR_W       = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int LAT_W       = $clog2(READ_LAT + 1);
    localparam int DEPTH_WORDS = 1 << ADDR_W;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LAT);

    localparam logic [0:0] IDLE      = 1'b0;
    localparam logic [0:0] READ_WAIT = 1'b1;

    logic [0:0]        state_reg;
    logic [LAT_W-1:0]  lat_cnt_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [PTR_W-1:0]  head_reg;
    logic [PTR_W-1:0]  tail_reg;
    logic [DATA_W-1:0] cap_reg;
    logic [DATA_W-1:0] q_reg;
    logic              q_valid_reg;

    logic [ADDR_W-1:0] buf_addr_reg [BUF_DEPTH];
    logic [DATA_W-1:0] buf_data_reg [BUF_DEPTH];
    logic [DATA_W-1:0] mem_reg      [DEPTH_WORDS];

    logic [BUF_DEPTH-1:0]       slot_hit;
    logic [BUF_DEPTH*PTR_W-1:0] slot_age;
    logic                       fwd_hit;
    logic [PTR_W-1:0]           fwd_slot;
    logic [PTR_W-1:0]           fwd_age;
    logic [DATA_W-1:0]          fwd_data;
    logic [DATA_W-1:0]          rd_value;

    logic full, rd_busy, wr_acc, rd_acc, merge, push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Age of each slot relative to the head (0 = oldest). A slot is live when
    // its age is below the occupancy; the subtraction wraps correctly because
    // the true age always fits in PTR_W bits.
    for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_slot
        logic [PTR_W-1:0] age;
        assign age = (PTR_W'(gi) >= head_reg) ? PTR_W'(gi) - head_reg
                                              : PTR_W'(gi + BUF_DEPTH) - head_reg;
        assign slot_age[gi*PTR_W +: PTR_W] = age;
        assign slot_hit[gi] = (CNT_W'(age) < count_reg) && (buf_addr_reg[gi] == endereco);
    end

    // Pick the youngest live entry matching the request address.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_slot = '0;
        fwd_age  = '0;
        for (int i = 0; i < BUF_DEPTH; i++) begin
            if (slot_hit[i] && (!fwd_hit || slot_age[i*PTR_W +: PTR_W] > fwd_age)) begin
                fwd_hit  = 1'b1;
                fwd_slot = PTR_W'(i);
                fwd_age  = slot_age[i*PTR_W +: PTR_W];
            end
        end
    end

    assign fwd_data = buf_data_reg[fwd_slot];
    assign rd_value = fwd_hit ? fwd_data : mem_reg[endereco];

    assign full    = (count_reg == FULL_CNT);
    assign rd_busy = (state_reg == READ_WAIT);

`ifdef WBUF_COALESCE_EN
    // A write hitting a pending entry needs no free slot, so fullness does
    // not block it.
    assign busy   = rd_busy | (full & ~(wren & fwd_hit));
    assign wr_acc = wren & ~busy;
    assign merge  = wr_acc & fwd_hit;
`else
    assign busy   = rd_busy | full;
    assign wr_acc = wren & ~busy;
    assign merge  = 1'b0;
`endif

    assign push   = wr_acc & ~merge;
    // Drain only on edges without an accepted write, so push and pop never coincide.
    assign pop    = (count_reg != '0) & ~wr_acc;
    assign rd_acc = rden & ~wren & ~busy;

    // Buffer payload needs no reset: occupancy alone decides what is live.
    always_ff @(posedge clock) begin
        if (push) begin
            buf_addr_reg[tail_reg] <= endereco;
            buf_data_reg[tail_reg] <= dado_in;
        end
        if (merge) begin
            buf_data_reg[fwd_slot] <= dado_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= IDLE;
            lat_cnt_reg <= '0;
            count_reg   <= '0;
            head_reg    <= '0;
            tail_reg    <= '0;
            cap_reg     <= '0;
            q_reg       <= '0;
            q_valid_reg <= 1'b0;
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            if (push) begin
                tail_reg <= ptr_inc(tail_reg);
            end
            if (pop) begin
                mem_reg[buf_addr_reg[head_reg]] <= buf_data_reg[head_reg];
                head_reg <= ptr_inc(head_reg);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase

            q_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (rd_acc) begin
                        // Captured now, so a later drain of the same entry cannot change it.
                        cap_reg     <= rd_value;
                        lat_cnt_reg <= LAT_W'(1);
                        state_reg   <= READ_WAIT;
                    end
                end
                default: begin
                    if (lat_cnt_reg == LAT_LAST) begin
                        q_reg       <= cap_reg;
                        q_valid_reg <= 1'b1;
                        state_reg   <= IDLE;
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg + 1'b1;
                    end
                end
            endcase
        end
    end

    assign q         = q_reg;
    assign q_valid   = q_valid_reg;
    assign buf_count = count_reg;

endmodule

// File: tb/tb_memoria_buffer_escrita.sv
module tb_memoria_buffer_escrita;

    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 3;
    localparam int BUF_DEPTH = 2;
    localparam int READ_LAT  = 2;

`ifdef WBUF_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif

    logic                           clock;
    logic                           reset;
    logic                           wren;
    logic                           rden;
    logic [ADDR_W-1:0]              endereco;
    logic [DATA_W-1:0]              dado_in;
    logic [DATA_W-1:0]              q;
    logic                           q_valid;
    logic                           busy;
    logic [$clog2(BUF_DEPTH+1)-1:0] buf_count;

    memoria_buffer_escrita #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .BUF_DEPTH(BUF_DEPTH),
        .READ_LAT (READ_LAT)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .wren     (wren),
        .rden     (rden),
        .endereco (endereco),
        .dado_in  (dado_in),
        .q        (q),
        .q_valid  (q_valid),
        .busy     (busy),
        .buf_count(buf_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: pending writes as an ordered queue, memory as a plain
    // array, an in-flight read as a countdown holding the captured value.
    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t              wq[$];
    logic [DATA_W-1:0] mem_m [1 << ADDR_W];
    logic              rd_pend = 1'b0;
    int                rd_left = 0;
    logic [DATA_W-1:0] rd_val  = '0;
    logic [DATA_W-1:0] q_m     = '0;
    logic              qv_m    = 1'b0;

    typedef struct {
        logic              w;
        logic              r;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic              eb;
        int                ec;
        logic              eqv;
        logic [DATA_W-1:0] eq;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic add(input logic w, input logic r, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic eb, input int ec,
                       input logic eqv, input logic [DATA_W-1:0] eq);
        vec_t v;
        v.w = w; v.r = r; v.a = a; v.d = d;
        v.eb = eb; v.ec = ec; v.eqv = eqv; v.eq = eq;
        vq.push_back(v);
    endtask

    // One clock cycle: drive, check busy against the model, advance the
    // model across the edge, then check the registered outputs.
    task automatic cycle(input logic rst_i, input logic w_i, input logic r_i,
                         input logic [ADDR_W-1:0] a_i, input logic [DATA_W-1:0] d_i,
                         output logic busy_seen);
        int   idx;
        logic hit, e_busy, wacc, racc;
        ent_t e;
        reset = rst_i; wren = w_i; rden = r_i; endereco = a_i; dado_in = d_i;
        #1;
        hit = 1'b0;
        idx = 0;
        for (int i = 0; i < wq.size(); i++) begin
            if (wq[i].a == a_i) begin
                hit = 1'b1;
                idx = i;
            end
        end
        e_busy = rd_pend || (wq.size() == BUF_DEPTH && !(COAL && w_i && hit));
        busy_seen = busy;
        if (!rst_i) check("busy", int'(busy), int'(e_busy));

        if (rst_i) begin
            wq.delete();
            for (int i = 0; i < (1 << ADDR_W); i++) mem_m[i] = '0;
            rd_pend = 1'b0;
            q_m     = '0;
            qv_m    = 1'b0;
        end else begin
            wacc = w_i && !e_busy;
            racc = r_i && !w_i && !e_busy;
            qv_m = 1'b0;
            if (rd_pend) begin
                rd_left--;
                if (rd_left == 0) begin
                    q_m     = rd_val;
                    qv_m    = 1'b1;
                    rd_pend = 1'b0;
                end
            end
            if (racc) begin
                rd_val  = hit ? wq[idx].d : mem_m[a_i];
                rd_pend = 1'b1;
                rd_left = READ_LAT;
            end
            if (wacc) begin
                if (COAL && hit) begin
                    e = wq[idx];
                    e.d = d_i;
                    wq[idx] = e;
                end else begin
                    wq.push_back({a_i, d_i});
                end
            end else if (wq.size() > 0) begin
                e = wq.pop_front();
                mem_m[e.a] = e.d;
            end
        end

        @(posedge clock);
        #1;
        check("buf_count", int'(buf_count), wq.size());
        check("q_valid", int'(q_valid), int'(qv_m));
        check("q", int'(q), int'(q_m));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic bs;
        logic rr, ww, rs;
        logic [ADDR_W-1:0] aa;
        logic [DATA_W-1:0] dd;

        // Directed vectors: {wren, rden, addr, data, busy before edge,
        //                    buf_count / q_valid / q after edge}
        // Cold read of an untouched address.
        add(0, 1, 5'h05, 3'b000, 0, 0, 0, 3'b000);
        add(0, 0, 5'h00, 3'b000, 1, 0, 0, 3'b000);
        add(0, 0, 5'h00, 3'b000, 1, 0, 1, 3'b000);
        add(0, 0, 5'h00, 3'b000, 0, 0, 0, 3'b000);
        // Forward from the buffer, then re-read from the array.
        add(1, 0, 5'h1A, 3'b011, 0, 1, 0, 3'b000);
        add(0, 1, 5'h1A, 3'b000, 0, 0, 0, 3'b000);
        add(0, 0, 5'h00, 3'b000, 1, 0, 0, 3'b000);
        add(0, 0, 5'h00, 3'b000, 1, 0, 1, 3'b011);
        add(0, 1, 5'h1A, 3'b000, 0, 0, 0, 3'b011);
        add(0, 0, 5'h00, 3'b000, 1, 0, 0, 3'b011);
        add(0, 0, 5'h00, 3'b000, 1, 0, 1, 3'b011);
        // Three writes into a two-entry buffer; the third is held once.
        add(1, 0, 5'h01, 3'b001, 0, 1, 0, 3'b011);
        add(1, 0, 5'h02, 3'b010, 0, 2, 0, 3'b011);
        add(1, 0, 5'h03, 3'b100, 1, 1, 0, 3'b011);
        add(1, 0, 5'h03, 3'b100, 0, 2, 0, 3'b011);
        add(0, 1, 5'h01, 3'b000, 1, 1, 0, 3'b011);
        add(0, 1, 5'h01, 3'b000, 0, 0, 0, 3'b011);
        add(0, 0, 5'h00, 3'b000, 1, 0, 0, 3'b011);
        add(0, 0, 5'h00, 3'b000, 1, 0, 1, 3'b001);
        add(0, 1, 5'h02, 3'b000, 0, 0, 0, 3'b001);
        add(0, 0, 5'h00, 3'b000, 1, 0, 0, 3'b001);
        add(0, 0, 5'h00, 3'b000, 1, 0, 1, 3'b010);
        add(0, 1, 5'h03, 3'b000, 0, 0, 0, 3'b010);
        add(0, 0, 5'h00, 3'b000, 1, 0, 0, 3'b010);
        add(0, 0, 5'h00, 3'b000, 1, 0, 1, 3'b100);
        // Same address written twice.
        add(1, 0, 5'h04, 3'b001, 0, 1, 0, 3'b100);
        add(1, 0, 5'h04, 3'b110, 0, COAL ? 1 : 2, 0, 3'b100);
        add(0, 0, 5'h00, 3'b000, COAL ? 1'b0 : 1'b1, COAL ? 0 : 1, 0, 3'b100);
        add(0, 1, 5'h04, 3'b000, 0, 0, 0, 3'b100);
        add(0, 0, 5'h00, 3'b000, 1, 0, 0, 3'b100);
        add(0, 0, 5'h00, 3'b000, 1, 0, 1, 3'b110);
        add(0, 1, 5'h04, 3'b000, 0, 0, 0, 3'b110);
        add(0, 0, 5'h00, 3'b000, 1, 0, 0, 3'b110);
        add(0, 0, 5'h00, 3'b000, 1, 0, 1, 3'b110);
        // Simultaneous wren/rden: only the write happens.
        add(1, 1, 5'h0F, 3'b101, 0, 1, 0, 3'b110);
        add(0, 0, 5'h00, 3'b000, 0, 0, 0, 3'b110);
        add(0, 0, 5'h00, 3'b000, 0, 0, 0, 3'b110);

        cycle(1, 0, 0, '0, '0, bs);
        cycle(1, 0, 0, '0, '0, bs);
        check("reset busy", int'(busy), 0);
        check("reset buf_count", int'(buf_count), 0);
        check("reset q", int'(q), 0);
        check("reset q_valid", int'(q_valid), 0);

        for (int i = 0; i < vq.size(); i++) begin
            cycle(0, vq[i].w, vq[i].r, vq[i].a, vq[i].d, bs);
            check($sformatf("vec%0d busy", i), int'(bs), int'(vq[i].eb));
            check($sformatf("vec%0d buf_count", i), int'(buf_count), vq[i].ec);
            check($sformatf("vec%0d q_valid", i), int'(q_valid), int'(vq[i].eqv));
            check($sformatf("vec%0d q", i), int'(q), int'(vq[i].eq));
            $display("vec %0d: w=%0d r=%0d a=%h d=%0d busy=%0d cnt=%0d qv=%0d q=%0d",
                     i, vq[i].w, vq[i].r, vq[i].a, vq[i].d, bs, buf_count, q_valid, q);
        end

        // Read aborted by reset on the edge after acceptance.
        cycle(0, 1, 0, 5'h08, 3'b101, bs);
        cycle(0, 0, 1, 5'h07, 3'b000, bs);
        check("abort accepted busy", int'(busy), 1);
        cycle(1, 0, 0, '0, '0, bs);
        check("abort busy", int'(busy), 0);
        check("abort buf_count", int'(buf_count), 0);
        check("abort q", int'(q), 0);
        for (int i = 0; i < 6; i++) begin
            cycle(0, 0, 0, '0, '0, bs);
            check($sformatf("abort no q_valid %0d", i), int'(q_valid), 0);
        end
        $display("abort sequence: busy=%0d cnt=%0d q=%0d", busy, buf_count, q);

        // Randomized traffic against the model, small address set for hits.
        for (int i = 0; i < 800; i++) begin
            rs = ($urandom_range(0, 99) == 0);
            ww = ($urandom_range(0, 2) == 0);
            rr = ($urandom_range(0, 1) == 1);
            aa = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 5));
            dd = DATA_W'($urandom);
            cycle(rs, ww, rr, aa, dd, bs);
            $display("rnd %0d: rst=%0d w=%0d r=%0d a=%h d=%0d busy=%0d cnt=%0d qv=%0d q=%0d",
                     i, rs, ww, rr, aa, dd, bs, buf_count, q_valid, q);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
